// File: rtl/wca_iq_sample_packer_pkg.sv
// Shared types, field positions and sample slicing helpers for the I/Q sample packer.
package wca_packer_pkg;

  localparam int SAMPLE_W  = 32;
  localparam int WORD_W    = 16;
  localparam int OVF_CNT_W = 8;
  localparam int I_LSB     = 0;
  localparam int Q_LSB     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_I = 2'd1,
    SEND_Q = 2'd2,
    SEND_P = 2'd3
  } pkr_state_e;

  function automatic logic [WORD_W-1:0] sample_i(input logic [SAMPLE_W-1:0] s);
    return s[I_LSB +: WORD_W];
  endfunction

  function automatic logic [WORD_W-1:0] sample_q(input logic [SAMPLE_W-1:0] s);
    return s[Q_LSB +: WORD_W];
  endfunction

  // Byte-pack keeps only the upper byte of each component (plain truncation).
  function automatic logic [WORD_W-1:0] sample_p8(input logic [SAMPLE_W-1:0] s);
    return {s[Q_LSB+8 +: 8], s[I_LSB+8 +: 8]};
  endfunction

endpackage

// File: rtl/wca_iq_sample_packer_if.sv
// Output word stream (valid/ready) between the packer and the host port FIFO.
interface wca_iq_sample_packer_if;
  import wca_packer_pkg::*;

  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);

endinterface

// File: rtl/wca_iq_sample_packer_fifo.sv
// wca_sync_fifo: single-clock FIFO with synchronous reset/flush and fall-through read data.
module wca_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;

  // Pointer and occupancy tracking; caller never pops empty or pushes full without a pop.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Sample storage.
  always_ff @(posedge clock) begin
    if (push) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = mem_r[rd_ptr_r];
  assign level = level_r;
  assign full  = (level_r == (AW+1)'(DEPTH));
  assign empty = (level_r == (AW+1)'(0));

endmodule

// File: rtl/wca_iq_sample_packer.sv
// Serializes strobed 32-bit I/Q samples into a 16-bit valid/ready word stream with overflow counting.
// WCA_PACKER_PACK8_EN builds the optional one-word-per-sample byte-pack mode.
module wca_iq_sample_packer
  import wca_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          pack8,
  input  logic                          dstrobe_in,
  input  logic [SAMPLE_W-1:0]           iq_in,
  input  logic                          clr_ovf,
  wca_iq_sample_packer_if.master        wbus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [OVF_CNT_W-1:0]          ovf_count
);
  pkr_state_e            state_r, state_nxt_s;
  logic [SAMPLE_W-1:0]   hold_r, hold_nxt_s, fifo_dout_s;
  logic                  fifo_full_s, fifo_empty_s, flush_s;
  logic                  strobe_s, push_s, pop_s, drop_s, pack8_s;
  logic [WORD_W-1:0]     word_r, word_nxt_s;
  logic                  valid_r, valid_nxt_s;
  logic                  overflow_r;
  logic [OVF_CNT_W-1:0]  ovf_count_r;

`ifdef WCA_PACKER_PACK8_EN
  assign pack8_s = pack8;
`else
  logic pack8_unused_s;
  assign pack8_unused_s = pack8;
  assign pack8_s        = 1'b0;
`endif

  // A full FIFO still accepts a sample when the serializer pops in the same cycle.
  assign strobe_s = enable & dstrobe_in;
  assign push_s   = strobe_s & (~fifo_full_s | pop_s);
  assign drop_s   = strobe_s & fifo_full_s & ~pop_s;
  assign flush_s  = ~enable;

  wca_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(SAMPLE_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush_s),
    .push  (push_s),
    .din   (iq_in),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .level (fifo_level),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // State and hold register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      hold_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      hold_r  <= hold_nxt_s;
    end
  end

  // Next state, FIFO pop and hold load.
  always_comb begin
    state_nxt_s = state_r;
    hold_nxt_s  = hold_r;
    pop_s       = 1'b0;
    if (!enable) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            pop_s       = 1'b1;
            hold_nxt_s  = fifo_dout_s;
            state_nxt_s = pack8_s ? SEND_P : SEND_I;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        SEND_I: begin
          if (wbus.word_ready) state_nxt_s = SEND_Q;
          else                 state_nxt_s = SEND_I;
        end
        SEND_Q: begin
          if (wbus.word_ready && !fifo_empty_s) begin
            pop_s       = 1'b1;
            hold_nxt_s  = fifo_dout_s;
            state_nxt_s = SEND_I;
          end else if (wbus.word_ready) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = SEND_Q;
          end
        end
`ifdef WCA_PACKER_PACK8_EN
        SEND_P: begin
          if (wbus.word_ready && !fifo_empty_s) begin
            pop_s       = 1'b1;
            hold_nxt_s  = fifo_dout_s;
            state_nxt_s = SEND_P;
          end else if (wbus.word_ready) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = SEND_P;
          end
        end
`endif
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Output word for the upcoming state, so word_out/word_valid come straight from flops.
  always_comb begin
    word_nxt_s  = 16'h0000;
    valid_nxt_s = 1'b0;
    case (state_nxt_s)
      SEND_I: begin
        word_nxt_s  = sample_i(hold_nxt_s);
        valid_nxt_s = 1'b1;
      end
      SEND_Q: begin
        word_nxt_s  = sample_q(hold_nxt_s);
        valid_nxt_s = 1'b1;
      end
`ifdef WCA_PACKER_PACK8_EN
      SEND_P: begin
        word_nxt_s  = sample_p8(hold_nxt_s);
        valid_nxt_s = 1'b1;
      end
`endif
      default: begin
        word_nxt_s  = 16'h0000;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_r  <= 16'h0000;
      valid_r <= 1'b0;
    end else begin
      word_r  <= word_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear leaves it set.
  always_ff @(posedge clock) begin
    if (reset)        overflow_r <= 1'b0;
    else if (drop_s)  overflow_r <= 1'b1;
    else if (clr_ovf) overflow_r <= 1'b0;
    else              overflow_r <= overflow_r;
  end

  // Saturating drop counter; clear takes priority over a coincident drop.
  always_ff @(posedge clock) begin
    if (reset)
      ovf_count_r <= {OVF_CNT_W{1'b0}};
    else if (clr_ovf)
      ovf_count_r <= {OVF_CNT_W{1'b0}};
    else if (drop_s && (ovf_count_r != {OVF_CNT_W{1'b1}}))
      ovf_count_r <= ovf_count_r + OVF_CNT_W'(1);
    else
      ovf_count_r <= ovf_count_r;
  end

  assign wbus.word_out   = word_r;
  assign wbus.word_valid = valid_r;
  assign overflow        = overflow_r;
  assign ovf_count       = ovf_count_r;

endmodule

// File: tb/tb_wca_iq_sample_packer.sv
// Directed self-checking bench for wca_iq_sample_packer; covers both WCA_PACKER_PACK8_EN builds.
module tb_wca_iq_sample_packer;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset, enable, pack8, dstrobe_in, clr_ovf;
  logic [31:0]   iq_in;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic [7:0]    ovf_count;
  int            err_cnt = 0;
  int            chk_cnt = 0;
  logic [15:0]   exp_words [6];

  wca_iq_sample_packer_if wif ();

  wca_iq_sample_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .pack8      (pack8),
    .dstrobe_in (dstrobe_in),
    .iq_in      (iq_in),
    .clr_ovf    (clr_ovf),
    .wbus       (wif),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .ovf_count  (ovf_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic strobe(input logic [31:0] v);
    dstrobe_in = 1'b1;
    iq_in      = v;
    step();
    dstrobe_in = 1'b0;
    iq_in      = 32'h0;
  endtask

  function automatic logic [31:0] samp(input int i);
    return {16'(16'hA000 + i), 16'(16'h0100 + i)};
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b1; pack8 = 1'b0; dstrobe_in = 1'b0;
    clr_ovf = 1'b0; iq_in = 32'h0; wif.word_ready = 1'b0;
    step(3);
    chk("rst_word", wif.word_out, 32'h0);
    chk("rst_valid", wif.word_valid, 32'h0);
    chk("rst_level", fifo_level, 32'h0);
    chk("rst_ovf", overflow, 32'h0);
    chk("rst_cnt", ovf_count, 32'h0);
    reset = 1'b0;

    // Single sample: level in N+1, I in N+2, Q in N+3, then idle.
    wif.word_ready = 1'b1;
    strobe(32'h1234ABCD);
    chk("single_lvl", fifo_level, 32'd1);
    chk("single_v0", wif.word_valid, 32'h0);
    step();
    chk("single_vi", wif.word_valid, 32'h1);
    chk("single_i", wif.word_out, 32'hABCD);
    step();
    chk("single_vq", wif.word_valid, 32'h1);
    chk("single_q", wif.word_out, 32'h1234);
    step();
    chk("single_idle", wif.word_valid, 32'h0);

    // Backpressure: first I frozen, two samples still queued, then six words in order.
    wif.word_ready = 1'b0;
    strobe(32'h11112222);
    strobe(32'h33334444);
    strobe(32'h55556666);
    step(10);
    chk("bp_word", wif.word_out, 32'h2222);
    chk("bp_valid", wif.word_valid, 32'h1);
    chk("bp_lvl", fifo_level, 32'd2);
    chk("bp_ovf", overflow, 32'h0);
    exp_words = '{16'h2222, 16'h1111, 16'h4444, 16'h3333, 16'h6666, 16'h5555};
    wif.word_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("bp_seq_v", wif.word_valid, 32'h1);
      chk("bp_seq_w", wif.word_out, 32'(exp_words[k]));
      step();
    end
    chk("bp_done", wif.word_valid, 32'h0);

    // Overflow: one sample parked in SEND_I, then 16 stored and 3 dropped.
    wif.word_ready = 1'b0;
    strobe(32'hDEADBEEF);
    step();
    chk("ovf_hold", wif.word_out, 32'hBEEF);
    for (int i = 0; i < DEPTH + 3; i++) strobe(samp(i));
    chk("ovf_lvl", fifo_level, 32'd16);
    chk("ovf_flag", overflow, 32'h1);
    chk("ovf_cnt", ovf_count, 32'd3);
    chk("ovf_frozen", wif.word_out, 32'hBEEF);

    // Full FIFO with a strobe coincident with the SEND_Q pop: accepted, nothing counted.
    wif.word_ready = 1'b1;
    step();
    chk("fp_q", wif.word_out, 32'hDEAD);
    strobe(samp(DEPTH + 3));
    wif.word_ready = 1'b0;
    chk("fp_lvl", fifo_level, 32'd16);
    chk("fp_cnt", ovf_count, 32'd3);
    chk("fp_word", wif.word_out, 32'h0100);

    // enable low flushes and ignores strobes, keeps overflow state.
    enable = 1'b0;
    step();
    strobe(32'hCAFEF00D);
    chk("dis_lvl", fifo_level, 32'd0);
    chk("dis_cnt", ovf_count, 32'd3);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) strobe(samp(i));
    chk("mid_lvl", fifo_level, 32'd5);
    wif.word_ready = 1'b1;
    step();
    wif.word_ready = 1'b0;
    chk("mid_q", wif.word_out, 32'hA000);
    enable = 1'b0;
    step();
    chk("mid_valid", wif.word_valid, 32'h0);
    chk("mid_lvl0", fifo_level, 32'd0);
    chk("mid_ovf", overflow, 32'h1);
    chk("mid_cnt", ovf_count, 32'd3);

    // Saturation at 255, clear racing a drop, then a plain clear.
    enable = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) strobe(samp(i));
    chk("sat_lvl", fifo_level, 32'd16);
    for (int i = 0; i < 256; i++) strobe(samp(i));
    chk("sat_cnt", ovf_count, 32'd255);
    clr_ovf = 1'b1;
    strobe(32'h0BADF00D);
    chk("clrdrop_cnt", ovf_count, 32'd0);
    chk("clrdrop_ovf", overflow, 32'h1);
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 32'h0);
    chk("clr_cnt", ovf_count, 32'd0);

    // Pack mode (or its absence), then a pack8 toggle in the middle of a pair.
    enable = 1'b0;
    step();
    enable = 1'b1;
    wif.word_ready = 1'b1;
    pack8 = 1'b1;
    strobe(32'h7F008000);
    step();
`ifdef WCA_PACKER_PACK8_EN
    chk("p8_word", wif.word_out, 32'h7F80);
    chk("p8_valid", wif.word_valid, 32'h1);
    step();
    chk("p8_idle", wif.word_valid, 32'h0);
`else
    chk("nop8_i", wif.word_out, 32'h8000);
    step();
    chk("nop8_q", wif.word_out, 32'h7F00);
    step();
    chk("nop8_idle", wif.word_valid, 32'h0);
`endif
    pack8 = 1'b0;
    wif.word_ready = 1'b0;
    strobe(32'h11223344);
    step();
    pack8 = 1'b1;
    wif.word_ready = 1'b1;
    chk("tog_i", wif.word_out, 32'h3344);
    step();
    chk("tog_q", wif.word_out, 32'h1122);
    chk("tog_vq", wif.word_valid, 32'h1);
    step();
    chk("tog_idle", wif.word_valid, 32'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/wca_iq_sample_packer.md
# wca_iq_sample_packer

Downstream stage of the DDC: takes the strobed 32-bit I/Q samples ({Q[15:0], I[15:0]}) the down converter produces and serializes them into a 16-bit valid/ready word stream for the host port FIFO. A small sample FIFO absorbs backpressure. Overflow is detected and counted rather than stalling the DSP chain. An optional 8-bit packing mode halves the link bandwidth.

## Interface
- FIFO_DEPTH, 16: sample FIFO depth in 32-bit entries; power of 2, minimum 4.
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = run; 0 = flush and hold idle.
- pack8  in  1  1 = one word per sample {Q[15:8], I[15:8]}; sampled only in IDLE.
- dstrobe_in  in  1  sample-valid strobe from the DDC, single-cycle pulses.
- iq_in  in  32  {Q[15:0], I[15:0]}, two's complement; valid when dstrobe_in=1.
- clr_ovf  in  1  pulse; clears overflow and ovf_count.
- word_out  out  16  output word.
- word_valid  out  1  word_out valid.
- word_ready  in  1  consumer accepts word when word_valid & word_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently stored.
- overflow  out  1  sticky: a sample was dropped.
- ovf_count  out  8  dropped-sample count, saturates at 255.

## Operation
- Reset values: word_out=0, word_valid=0, fifo_level=0, overflow=0, ovf_count=0, state IDLE.
- Write: when enable & dstrobe_in, push iq_in if fifo_level<FIFO_DEPTH or a pop occurs the same cycle. Otherwise drop the sample, set overflow, and increment ovf_count (saturating).
- clr_ovf together with a drop in the same cycle: clear wins for ovf_count (0), but overflow ends up 1.
- enable=0: FIFO pointers cleared, state forced to IDLE, word_valid=0, incoming strobes ignored and not counted. overflow and ovf_count are kept.
- Serializer FSM:
  - IDLE: if fifo_level!=0, pop into hold register. Go to SEND_I, or to SEND_P if pack8 (latched).
  - SEND_I: word_out=I; on accept, go to SEND_Q.
  - SEND_Q: word_out=Q. On accept, if FIFO is non-empty, pop and go to SEND_I; else go to IDLE.
  - SEND_P: word_out={Q[15:8], I[15:8]}. On accept, if FIFO is non-empty, pop and stay in SEND_P; else go to IDLE.
- word_valid=1 exactly in the SEND states. word_out is held stable while valid & !ready.
- pack8 changes take effect only at the next IDLE→SEND transition. A pair in progress always completes.
- Truncation in pack8 is plain bit-select, no rounding.

## Timing
- Strobe in cycle N: entry written at the end of N, fifo_level increments in N+1, pop in N+1, first word valid in N+2.
- Steady state with word_ready=1:
  - 16-bit mode: 2 words per sample, no bubbles between samples.
  - pack8 mode: 1 word per cycle.
- fifo_level reflects the registered count. A push and a pop in the same cycle leave it unchanged.
- Reset or enable deassert mid-pair: the pair is discarded and word_valid drops the next cycle.

## Configuration
- WCA_PACKER_PACK8_EN defined: pack8 input honoured, SEND_P state and byte-pack mux built.
- Not defined: pack8 ignored (treated as 0), SEND_P not generated, output is always I then Q 16-bit words.

## Structure
- Package wca_packer_pkg:
  - state enum (IDLE, SEND_I, SEND_Q, SEND_P);
  - OVF_CNT_W=8;
  - sample field slice constants (I_LSB=0, Q_LSB=16).
- Sub-module wca_sync_fifo: single-clock 32-bit FIFO, synchronous reset and flush, push/pop/level/full/empty.
- The FSM, hold register and overflow logic live in the top module.

## Test plan
- Single sample: iq_in=0x1234ABCD strobed at cycle 0 with ready=1 → word_valid in cycle 2 with 0xABCD, cycle 3 with 0x1234, then idle.
- Backpressure: 3 samples, word_ready=0 for 10 cycles → word_out frozen at the first I, fifo_level=2, no loss; releasing ready yields 6 words in order.
- Overflow: ready=0, FIFO_DEPTH+3 strobes → fifo_level=16, overflow=1, ovf_count=3; clr_ovf → both 0.
- Full plus same-cycle pop: FIFO full, strobe coincident with a pop → sample accepted, ovf_count unchanged.
- pack8 (macro defined): iq_in=0x7F00_8000 → single word 0x7F80; pack8 toggled mid-pair → current pair completes in 16-bit mode.
- enable dropped while in SEND_Q with 5 entries → next cycle word_valid=0, fifo_level=0, overflow retained.
